seg7_scan_ctrl: RTL and testbench

- Time-multiplexing scan controller that shares one hex-to-7-segment decoder (4-bit nibble in, 7-bit segments out) across DIGITS common-anode digits.
- Holds a shadow copy of the display word and selects one digit at a time.
- Drives the selected nibble to the decoder and inserts blanking dead-time between digits to suppress ghosting.
- Sits between the system value registers and the board's segment/anode pins.

---
 rtl/seg7_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// One shared decoder; blank dead-time between digits suppresses ghosting.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   iData,
  input  logic                  iLoad,
  input  logic [DIGITS-1:0]     iEnable,
  output logic [DIGITS-1:0]     oSel,
  output logic [3:0]            oNibble,
  output logic [2:0]            oIdx,
  output logic                  oFrame
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} stateT;

  stateT               state;
  logic [4*DIGITS-1:0] shadow;
  logic [2:0]          idx;
  logic [CNT_W-1:0]    cnt;

  logic [DIGITS-1:0]   rotated;
  logic [2:0]          offset;
  logic [3:0]          sum;
  logic [2:0]          nextIdx;
  logic [2:0]          firstIdx;
  logic [2:0]          target;
  logic [3:0]          targetNib;
  logic [DIGITS-1:0]   targetSel;
  logic                curEn;
  logic                anyEn;

  function automatic logic [2:0] lowestSet(input logic [DIGITS-1:0] v);
    logic [2:0] r;
    logic       hit;
    r   = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!hit && v[i]) begin
        r   = 3'(i);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  // Circular search from idx+1: rotate the mask so bit 0 is idx+1, take the
  // lowest set bit, then fold the offset back modulo DIGITS.
  always_comb begin
    rotated  = DIGITS'({iEnable, iEnable} >> ({1'b0, idx} + 4'd1));
    offset   = lowestSet(rotated);
    sum      = {1'b0, idx} + 4'd1 + {1'b0, offset};
    if (sum >= 4'(DIGITS)) begin
      sum = sum - 4'(DIGITS);
    end
    nextIdx  = sum[2:0];
    firstIdx = lowestSet(iEnable);
    target   = (state == IDLE) ? firstIdx : nextIdx;
    anyEn    = |iEnable;
    targetNib = '0;
    targetSel = '1;
    curEn     = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (target == 3'(i)) begin
        targetNib    = shadow[4*i +: 4];
        targetSel[i] = 1'b0;
      end
      if (idx == 3'(i)) begin
        curEn = iEnable[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shadow  <= '0;
      idx     <= '0;
      cnt     <= '0;
      oSel    <= '1;
      oNibble <= '0;
      oIdx    <= '0;
      oFrame  <= 1'b0;
    end else begin
      if (iLoad) begin
        shadow <= iData;
      end
      oFrame <= 1'b0;
      unique case (state)
        IDLE: begin
          oSel <= '1;
          if (anyEn) begin
            state   <= SHOW;
            idx     <= target;
            oIdx    <= target;
            oSel    <= targetSel;
            oNibble <= targetNib;
            cnt     <= '0;
          end
        end
        SHOW: begin
          if (!anyEn) begin
            state <= IDLE;
            oSel  <= '1;
            cnt   <= '0;
          end else if (!curEn || cnt == CNT_W'(SCAN_DIV - 1)) begin
            state <= BLANK;
            oSel  <= '1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BLANK: begin
          oSel <= '1;
          if (cnt == CNT_W'(BLANK_CYC - 1)) begin
            cnt <= '0;
            if (!anyEn) begin
              state <= IDLE;
            end else begin
              state   <= SHOW;
              idx     <= target;
              oIdx    <= target;
              oSel    <= targetSel;
              oNibble <= targetNib;
              oFrame  <= (nextIdx <= idx);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          oSel  <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with DIGITS=4, SCAN_DIV=4, BLANK_CYC=1.
// Expected per-cycle outputs are queued from hand-derived scan sequences.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] iData = '0;
  logic        iLoad = 1'b0;
  logic [3:0]  iEnable = '0;
  logic [3:0]  oSel;
  logic [3:0]  oNibble;
  logic [2:0]  oIdx;
  logic        oFrame;

  int passCnt = 0;
  int totalCnt = 0;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] nib;
    logic [2:0] idx;
    logic       frame;
  } expT;

  expT expQ[$];

  seg7_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .iData   (iData),
    .iLoad   (iLoad),
    .iEnable (iEnable),
    .oSel    (oSel),
    .oNibble (oNibble),
    .oIdx    (oIdx),
    .oFrame  (oFrame)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic expOne(input logic [3:0] sel, input logic [3:0] nib,
                        input logic [2:0] idx, input logic frame);
    expT e;
    e.sel = sel; e.nib = nib; e.idx = idx; e.frame = frame;
    expQ.push_back(e);
  endtask

  // Digit d lit for 4 cycles; frame pulse (if any) only on the entry cycle.
  task automatic expShow(input int d, input logic [3:0] nib, input logic frame);
    logic [3:0] sel;
    sel = 4'hF;
    sel[d] = 1'b0;
    for (int i = 0; i < 4; i++) expOne(sel, nib, 3'(d), (i == 0) ? frame : 1'b0);
  endtask

  task automatic expBlank(input int d, input logic [3:0] nib);
    expOne(4'hF, nib, 3'(d), 1'b0);
  endtask

  task automatic runQ();
    expT e;
    while (expQ.size() > 0) begin
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      checkVal("oSel", 32'(oSel), 32'(e.sel));
      checkVal("oNibble", 32'(oNibble), 32'(e.nib));
      checkVal("oIdx", 32'(oIdx), 32'(e.idx));
      checkVal("oFrame", 32'(oFrame), 32'(e.frame));
      checkVal("oneLow", 32'($countones(~oSel) <= 1), 32'(1));
    end
  endtask

  task automatic resetLoad(input logic [15:0] data);
    rst = 1'b1;
    iEnable = '0;
    iLoad = 1'b0;
    expOne(4'hF, 4'h0, 3'd0, 1'b0);
    runQ();
    rst = 1'b0;
    iData = data;
    iLoad = 1'b1;
    expOne(4'hF, 4'h0, 3'd0, 1'b0);
    runQ();
    iLoad = 1'b0;
  endtask

  initial begin
    // Full four-digit scan with wrap back to digit 0
    resetLoad(16'h3210);
    iEnable = 4'hF;
    expShow(0, 4'h0, 1'b0); expBlank(0, 4'h0);
    expShow(1, 4'h1, 1'b0); expBlank(1, 4'h1);
    expShow(2, 4'h2, 1'b0); expBlank(2, 4'h2);
    expShow(3, 4'h3, 1'b0); expBlank(3, 4'h3);
    expShow(0, 4'h0, 1'b1);
    runQ();

    // Sparse mask: digits 0 and 2 alternate, period 10
    resetLoad(16'hA5C3);
    iEnable = 4'b0101;
    expShow(0, 4'h3, 1'b0); expBlank(0, 4'h3);
    expShow(2, 4'h5, 1'b0); expBlank(2, 4'h5);
    expShow(0, 4'h3, 1'b1); expBlank(0, 4'h3);
    expShow(2, 4'h5, 1'b0); expBlank(2, 4'h5);
    expShow(0, 4'h3, 1'b1);
    runQ();

    // Single enabled digit re-lit after each blank
    resetLoad(16'hA5C3);
    iEnable = 4'b1000;
    expShow(3, 4'hA, 1'b0); expBlank(3, 4'hA);
    expShow(3, 4'hA, 1'b1); expBlank(3, 4'hA);
    expShow(3, 4'hA, 1'b1);
    runQ();

    // Load during digit 1's SHOW shows up only on digit 2
    resetLoad(16'h3210);
    iEnable = 4'hF;
    expShow(0, 4'h0, 1'b0); expBlank(0, 4'h0);
    expOne(4'b1101, 4'h1, 3'd1, 1'b0);
    runQ();
    iData = 16'h7654;
    iLoad = 1'b1;
    expOne(4'b1101, 4'h1, 3'd1, 1'b0);
    runQ();
    iLoad = 1'b0;
    expOne(4'b1101, 4'h1, 3'd1, 1'b0);
    expOne(4'b1101, 4'h1, 3'd1, 1'b0);
    expBlank(1, 4'h1);
    expShow(2, 4'h6, 1'b0);
    runQ();

    // Early blank on disable, then IDLE on empty mask
    resetLoad(16'h3210);
    iEnable = 4'hF;
    expShow(0, 4'h0, 1'b0); expBlank(0, 4'h0);
    expOne(4'b1101, 4'h1, 3'd1, 1'b0);
    expOne(4'b1101, 4'h1, 3'd1, 1'b0);
    runQ();
    iEnable = 4'b1101;
    expBlank(1, 4'h1);
    expOne(4'b1011, 4'h2, 3'd2, 1'b0);
    expOne(4'b1011, 4'h2, 3'd2, 1'b0);
    runQ();
    iEnable = 4'b0000;
    expOne(4'hF, 4'h2, 3'd2, 1'b0);
    expOne(4'hF, 4'h2, 3'd2, 1'b0);
    runQ();

    // Reset mid-SHOW of digit 2 clears outputs and shadow
    resetLoad(16'h3210);
    iEnable = 4'hF;
    expShow(0, 4'h0, 1'b0); expBlank(0, 4'h0);
    expShow(1, 4'h1, 1'b0); expBlank(1, 4'h1);
    expOne(4'b1011, 4'h2, 3'd2, 1'b0);
    expOne(4'b1011, 4'h2, 3'd2, 1'b0);
    runQ();
    rst = 1'b1;
    expOne(4'hF, 4'h0, 3'd0, 1'b0);
    runQ();
    rst = 1'b0;
    expShow(0, 4'h0, 1'b0); expBlank(0, 4'h0);
    expShow(1, 4'h0, 1'b0);
    runQ();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
